mem_mfc_unit: RTL and testbench
===============================

Name: mem_mfc_unit

Overview:
- Main-memory block on the CPU memory bus, directly downstream of the Store and Load control FSMs.
- Accepts an access request on MEM_EN/MEM_RW, using the MAR-driven address and the MDR-driven write data.
- Performs the read or write after a fixed access latency, then signals completion with a one-cycle MFC (memory function complete) pulse.
- Word-addressed synchronous RAM wrapped in a request/complete handshake FSM.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- LATENCY, 3, cycles from request acceptance to the MFC pulse; legal range 1..15

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- MEM_EN  in  1  access request, held high by the master until MFC is seen
- MEM_RW  in  1  access type: 1 = read, 0 = write; sampled only at acceptance
- addr  in  ADDR_W  word address from MAR; sampled at acceptance
- wdata  in  DATA_W  write data from MDR; sampled at acceptance
- rdata  out  DATA_W  read data for MDR_mem_read; valid from the MFC cycle onward
- MFC  out  1  completion pulse, exactly one cycle per accepted access
- busy  out  1  high from acceptance until the request is released

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, MFC=0, busy=0, rdata=0, latency counter=0.
  - RAM contents are not cleared.
  - Reset has priority over every other input.
- States: IDLE, ACCESS, COMPLETE, RELEASE.
- IDLE:
  - If MEM_EN=1 at the clock edge: latch addr, wdata and MEM_RW; load counter with LATENCY-1; busy=1; go to ACCESS.
  - Otherwise remain in IDLE.
- ACCESS:
  - If counter != 0: decrement and stay in ACCESS.
  - If counter == 0: perform the access using the latched values.
    - Write: RAM[addr_l] <= wdata_l.
    - Read: rdata <= RAM[addr_l].
  - Then go to COMPLETE.
- COMPLETE:
  - MFC=1 for this single cycle; busy stays 1.
  - Next state is always RELEASE.
- RELEASE:
  - MFC=0, busy=1.
  - When MEM_EN=0, go to IDLE and set busy=0.
  - While MEM_EN stays high, remain in RELEASE. A held request never retriggers a second access.
- Latency: request accepted on edge N → MFC high during the cycle after edge N+LATENCY. With LATENCY=3, acceptance at edge 0 gives MFC high between edges 3 and 4.
- Address, data and type changes after acceptance are ignored until the next IDLE acceptance.
- MEM_EN dropped during ACCESS: the access still completes and MFC still pulses. The block does not abort on request withdrawal.
- rdata:
  - Updates only on read completion.
  - Holds its value through subsequent writes and idle cycles.
  - A write never changes rdata, even to the same address.
- Back-to-back requests: minimum spacing is one IDLE cycle after MEM_EN falls; re-acceptance happens on the first edge in IDLE with MEM_EN=1.
- Reset during ACCESS: access aborted, RAM untouched (no partial write), no MFC.
- Reset during COMPLETE: MFC cleared on that edge.
- Address width: no wrap logic needed; addr is exactly ADDR_W bits.
- No internal forwarding: a read issued after a completed write to the same address returns the written value.

Test Plan:
- Reset values: assert reset for 1 cycle with MEM_EN=0 → MFC=0, busy=0, rdata=0x0000, state IDLE.
- Write then read: write addr=0x05 data=0xBEEF (MEM_RW=0), hold MEM_EN until MFC. Then read addr=0x05 → MFC pulses exactly 1 cycle, 3 cycles after acceptance each time; rdata=0xBEEF in the read's MFC cycle.
- Held request: keep MEM_EN=1 for 20 cycles on a read → exactly one MFC pulse, busy stays 1 until MEM_EN falls, then 0 the next cycle.
- Input change after acceptance: accept write addr=0x10 data=0x1234, then change addr=0x11 data=0xFFFF next cycle → reading 0x10 returns 0x1234; reading 0x11 returns its prior value.
- Reset mid-access: accept write addr=0x20 data=0xAAAA (0x20 previously holds 0x5555), pulse reset 1 cycle later → no MFC, busy=0, and a later read of 0x20 returns 0x5555.
- Rdata hold and back-to-back: read 0x05 (0xBEEF), then write 0x06=0x0001 with MEM_EN dropped for 1 cycle between requests → second access accepted immediately, rdata still 0xBEEF after the write's MFC.

Source files
------------

// File: rtl/mem_mfc_if.sv
// Memory bus between the Store/Load control FSMs (master) and main memory (slave).
interface mem_mfc_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              MEM_EN;
  logic              MEM_RW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              MFC;
  logic              busy;

  modport master (
    output MEM_EN, MEM_RW, addr, wdata,
    input  rdata, MFC, busy
  );

  modport slave (
    input  MEM_EN, MEM_RW, addr, wdata,
    output rdata, MFC, busy
  );
endinterface

// File: rtl/mem_mfc_unit.sv
// Main memory: word-addressed synchronous RAM behind a request/MFC handshake.
// An accepted request is serviced LATENCY cycles later, then MFC pulses once;
// the block waits for MEM_EN to drop before accepting another request.
module mem_mfc_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic     clk,
  input  logic     reset,
  mem_mfc_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic              rw_l;
  logic [DATA_W-1:0] rdata_q;
  logic              mfc_q, mfc_nxt;
  logic              busy_q, busy_nxt;
  logic              accept_c, access_c, ram_we_c, rd_en_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.MEM_EN) state_nxt = ACCESS;
      ACCESS:   if (cnt == '0) state_nxt = COMPLETE;
      COMPLETE: state_nxt = RELEASE;
      RELEASE:  if (!bus.MEM_EN) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output / datapath control; MFC and busy are registered from these.
  always_comb begin
    cnt_nxt  = cnt;
    accept_c = 1'b0;
    access_c = 1'b0;
    mfc_nxt  = 1'b0;
    busy_nxt = busy_q;
    case (state)
      IDLE: begin
        if (bus.MEM_EN) begin
          accept_c = 1'b1;
          cnt_nxt  = CNT_W'(LATENCY - 1);
          busy_nxt = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          access_c = 1'b1;
          mfc_nxt  = 1'b1;
        end
      end
      COMPLETE: busy_nxt = 1'b1;
      RELEASE:  if (!bus.MEM_EN) busy_nxt = 1'b0;
      default:  busy_nxt = 1'b0;
    endcase
  end

  // Reset gates the write strobe so an aborted access never touches the RAM.
  assign ram_we_c = access_c & ~rw_l & ~reset;
  assign rd_en_c  = access_c & rw_l;

  // Request latches, latency counter, registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      addr_l  <= '0;
      wdata_l <= '0;
      rw_l    <= 1'b0;
      rdata_q <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      mfc_q  <= mfc_nxt;
      busy_q <= busy_nxt;
      if (accept_c) begin
        addr_l  <= bus.addr;
        wdata_l <= bus.wdata;
        rw_l    <= bus.MEM_RW;
      end
      if (rd_en_c) rdata_q <= mem[addr_l];
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) mem[addr_l] <= wdata_l;
  end

  assign bus.rdata = rdata_q;
  assign bus.MFC   = mfc_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_mfc_unit.sv
// Directed bench for mem_mfc_unit: handshake timing, read/write data, reset abort.
module tb_mem_mfc_unit;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LATENCY = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mem_mfc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_mfc_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full handshake. After acceptance the bus inputs are scrambled to
  // a2/d2/~rw so any use of unlatched inputs shows up. Request is held for
  // 'hold' extra cycles past MFC, then released.
  task automatic access(input string tag, input logic rw, input logic [7:0] a,
                        input logic [15:0] d, input logic [7:0] a2, input logic [15:0] d2,
                        input int hold, output logic [15:0] rd);
    int   lat;
    int   pulses;
    logic seen;
    lat    = 0;
    pulses = 0;
    seen   = 1'b0;
    rd     = '0;
    bus.MEM_EN = 1'b1;
    bus.MEM_RW = rw;
    bus.addr   = a;
    bus.wdata  = d;
    for (int k = 1; k <= int'(LATENCY) + 1 + hold; k++) begin
      tick();
      if (k == 1) begin
        bus.MEM_RW = ~rw;
        bus.addr   = a2;
        bus.wdata  = d2;
      end
      if (bus.MFC) begin
        pulses++;
        if (!seen) begin
          seen = 1'b1;
          lat  = k;
          rd   = bus.rdata;
        end
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(LATENCY + 1));
    check({tag, "_busy_held"}, 32'(bus.busy), 32'd1);
    bus.MEM_EN = 1'b0;
    tick();
    if (bus.MFC) pulses++;
    tick();
    if (bus.MFC) pulses++;
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_busy_released"}, 32'(bus.busy), 32'd0);
  endtask

  logic [15:0] rd;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    bus.MEM_EN = 1'b0;
    bus.MEM_RW = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    tick();
    reset = 1'b0;
    check("rst_mfc", 32'(bus.MFC), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'h0);

    // Write then read back.
    access("wr05", 1'b0, 8'h05, 16'hBEEF, 8'h33, 16'h0BAD, 0, rd);
    check("wr05_rdata", 32'(rd), 32'h0);
    access("rd05", 1'b1, 8'h05, 16'h0000, 8'h33, 16'h0BAD, 0, rd);
    check("rd05_rdata", 32'(rd), 32'hBEEF);

    // Held read: exactly one MFC across 20 extra held cycles.
    access("held", 1'b1, 8'h05, 16'h0000, 8'h44, 16'h0000, 20, rd);
    check("held_rdata", 32'(rd), 32'hBEEF);

    // Inputs changed after acceptance are ignored.
    access("wr11", 1'b0, 8'h11, 16'h7777, 8'h00, 16'h0000, 0, rd);
    access("wr10", 1'b0, 8'h10, 16'h1234, 8'h11, 16'hFFFF, 0, rd);
    access("rd10", 1'b1, 8'h10, 16'h0000, 8'h11, 16'hFFFF, 0, rd);
    check("rd10_rdata", 32'(rd), 32'h1234);
    access("rd11", 1'b1, 8'h11, 16'h0000, 8'h10, 16'h0000, 0, rd);
    check("rd11_rdata", 32'(rd), 32'h7777);

    // Reset one cycle after acceptance aborts the write.
    access("wr20", 1'b0, 8'h20, 16'h5555, 8'h00, 16'h0000, 0, rd);
    bus.MEM_EN = 1'b1;
    bus.MEM_RW = 1'b0;
    bus.addr   = 8'h20;
    bus.wdata  = 16'hAAAA;
    tick();
    check("abort_busy_accept", 32'(bus.busy), 32'd1);
    reset      = 1'b1;
    bus.MEM_EN = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rdata", 32'(bus.rdata), 32'h0);
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (bus.MFC) pulses++;
      end
      check("abort_no_mfc", 32'(pulses), 32'd0);
    end
    access("rd20", 1'b1, 8'h20, 16'h0000, 8'h00, 16'h0000, 0, rd);
    check("rd20_rdata", 32'(rd), 32'h5555);

    // rdata holds across a back-to-back write.
    access("rd05b", 1'b1, 8'h05, 16'h0000, 8'h06, 16'h0000, 0, rd);
    check("rd05b_rdata", 32'(rd), 32'hBEEF);
    access("wr06", 1'b0, 8'h06, 16'h0001, 8'h05, 16'h9999, 0, rd);
    check("wr06_rdata_at_mfc", 32'(rd), 32'hBEEF);
    check("wr06_rdata_after", 32'(bus.rdata), 32'hBEEF);
    access("rd06", 1'b1, 8'h06, 16'h0000, 8'h05, 16'h0000, 0, rd);
    check("rd06_rdata", 32'(rd), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
